// File: rtl/bus_sequencer_if.sv
// Bus sequencer interface: bundles the requester handshakes (CPU, video,
// SPI bridge) and the multiplexed system-bus outputs.
//   master modport : used by the sequencer (requests in, bus/acks out)
//   slave  modport : used by whatever drives the requesters and observes the bus
interface bus_sequencer_if;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic        video_req;
    logic [11:0] video_addr;
    logic        video_ack;
    logic        spi_req;
    logic [16:0] spi_addr;
    logic        spi_we;
    logic        spi_ack;
    logic [16:0] bus_addr;
    logic        bus_we;
    logic        bus_strobe;
    logic [1:0]  owner;
    logic        cpu_clk_en;

    modport master (
        input  cpu_addr, cpu_we, video_req, video_addr, spi_req, spi_addr, spi_we,
        output video_ack, spi_ack, bus_addr, bus_we, bus_strobe, owner, cpu_clk_en
    );

    modport slave (
        output cpu_addr, cpu_we, video_req, video_addr, spi_req, spi_addr, spi_we,
        input  video_ack, spi_ack, bus_addr, bus_we, bus_strobe, owner, cpu_clk_en
    );
endinterface

// File: rtl/bus_sequencer.sv
// PET system-bus initiator. Time-multiplexes video fetch, the 6502 CPU and
// the SPI host bridge onto one 17-bit bus address in a fixed frame of
// VIDEO, CPU, SPI slots of SLOT_CLKS clocks each. One frame is one 6502
// cycle; cpu_clk_en pulses on the last clock of every CPU slot.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : bus_sequencer_if.master (requests in; bus_addr/bus_we/
//           bus_strobe/owner, acks and cpu_clk_en out, all registered)
module bus_sequencer #(
    parameter int          SLOT_CLKS = 4,
    parameter logic [16:0] VRAM_BASE = 17'h08000
) (
    input  logic              clk,
    input  logic              reset,
    bus_sequencer_if.master   bus
);

    typedef enum logic [1:0] {
        S_VIDEO = 2'd0,
        S_CPU   = 2'd1,
        S_SPI   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST       = 4'(SLOT_CLKS - 1);
    localparam logic [3:0] CNT_STROBE_MAX = 4'(SLOT_CLKS - 2);

    localparam logic [1:0] OWNER_NONE  = 2'd0;
    localparam logic [1:0] OWNER_VIDEO = 2'd1;
    localparam logic [1:0] OWNER_CPU   = 2'd2;
    localparam logic [1:0] OWNER_SPI   = 2'd3;

    // state_r/cnt_r name the slot position that the next clock edge enters;
    // all outputs are registered from that position on the same edge.
    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        grant_r, grant_s;

    logic [16:0] bus_addr_r, bus_addr_s;
    logic        bus_we_r, bus_we_s;
    logic        bus_strobe_r, bus_strobe_s;
    logic [1:0]  owner_r, owner_s;
    logic        video_ack_r, video_ack_s;
    logic        spi_ack_r, spi_ack_s;
    logic        cpu_clk_en_r, cpu_clk_en_s;

    // Slot state, slot counter and latched grant register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_VIDEO;
            cnt_r   <= 4'd0;
            grant_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            grant_r <= grant_s;
        end
    end

    // Next slot position, grant sampling at slot entry, and next output values.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r + 4'd1;
        grant_s      = grant_r;
        bus_addr_s   = bus_addr_r;
        bus_we_s     = bus_we_r;
        owner_s      = owner_r;
        bus_strobe_s = 1'b0;
        video_ack_s  = 1'b0;
        spi_ack_s    = 1'b0;
        cpu_clk_en_s = 1'b0;

        if (cnt_r == CNT_LAST) begin
            cnt_s = 4'd0;
            case (state_r)
                S_VIDEO: state_s = S_CPU;
                S_CPU:   state_s = S_SPI;
                S_SPI:   state_s = S_VIDEO;
                default: state_s = S_VIDEO;
            endcase
        end else begin
            cnt_s = cnt_r + 4'd1;
        end

        // Slot entry: requests and addresses are sampled only here; the
        // registered values then hold for the rest of the slot.
        if (cnt_r == 4'd0) begin
            case (state_r)
                S_VIDEO: begin
                    grant_s    = bus.video_req;
                    bus_addr_s = VRAM_BASE | {5'b0_0000, bus.video_addr};
                    bus_we_s   = 1'b0;
                    owner_s    = OWNER_VIDEO;
                end
                S_CPU: begin
                    grant_s    = 1'b1;
                    bus_addr_s = {1'b0, bus.cpu_addr};
                    bus_we_s   = bus.cpu_we;
                    owner_s    = OWNER_CPU;
                end
                S_SPI: begin
                    grant_s    = bus.spi_req;
                    bus_addr_s = bus.spi_addr;
                    bus_we_s   = bus.spi_we;
                    owner_s    = OWNER_SPI;
                end
                default: begin
                    grant_s    = 1'b0;
                    bus_addr_s = bus_addr_r;
                    bus_we_s   = 1'b0;
                    owner_s    = OWNER_NONE;
                end
            endcase
            // An ungranted slot keeps the old address but drives no owner/write.
            if (!grant_s) begin
                bus_addr_s = bus_addr_r;
                bus_we_s   = 1'b0;
                owner_s    = OWNER_NONE;
            end else begin
                bus_addr_s = bus_addr_s;
            end
        end else begin
            grant_s = grant_r;
        end

        // Strobe stays off on the first and last clock of a slot so the
        // address is settled before and after the qualifier.
        if (grant_s && (cnt_r >= 4'd1) && (cnt_r <= CNT_STROBE_MAX)) begin
            bus_strobe_s = 1'b1;
        end else begin
            bus_strobe_s = 1'b0;
        end

        if (cnt_r == CNT_LAST) begin
            video_ack_s  = grant_s && (state_r == S_VIDEO);
            spi_ack_s    = grant_s && (state_r == S_SPI);
            cpu_clk_en_s = (state_r == S_CPU);
        end else begin
            video_ack_s  = 1'b0;
            spi_ack_s    = 1'b0;
            cpu_clk_en_s = 1'b0;
        end
    end

    // Registered bus outputs and single-clock pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_addr_r   <= 17'h0_0000;
            bus_we_r     <= 1'b0;
            bus_strobe_r <= 1'b0;
            owner_r      <= OWNER_NONE;
            video_ack_r  <= 1'b0;
            spi_ack_r    <= 1'b0;
            cpu_clk_en_r <= 1'b0;
        end else begin
            bus_addr_r   <= bus_addr_s;
            bus_we_r     <= bus_we_s;
            bus_strobe_r <= bus_strobe_s;
            owner_r      <= owner_s;
            video_ack_r  <= video_ack_s;
            spi_ack_r    <= spi_ack_s;
            cpu_clk_en_r <= cpu_clk_en_s;
        end
    end

    assign bus.bus_addr   = bus_addr_r;
    assign bus.bus_we     = bus_we_r;
    assign bus.bus_strobe = bus_strobe_r;
    assign bus.owner      = owner_r;
    assign bus.video_ack  = video_ack_r;
    assign bus.spi_ack    = spi_ack_r;
    assign bus.cpu_clk_en = cpu_clk_en_r;

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Initiator side of the PET system bus: time-multiplexes video fetch, 6502 CPU and SPI host bridge onto a single 17-bit bus address.
- The existing address decoder consumes the resulting bus address and turns it into RAM/IO chip enables.
- Generates the CPU clock-enable, so one bus frame equals exactly one 6502 cycle.
- Fixed slot order per frame: VIDEO, CPU, SPI.

Parameters:
- SLOT_CLKS, 4, clocks per slot; legal range 3..16; frame length = 3*SLOT_CLKS clocks.
- VRAM_BASE, 17'h08000, base OR'd onto video_addr to form the bus address.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  16  6502 address; bus_addr[16] forced 0 in CPU slot
- cpu_we  in  1  6502 write (active high)
- video_req  in  1  video fetch request
- video_addr  in  12  VRAM offset
- video_ack  out  1  1-clock pulse: video access complete
- spi_req  in  1  SPI bridge request; level, held until spi_ack
- spi_addr  in  17  SPI bridge address (full 17 bits)
- spi_we  in  1  SPI bridge write
- spi_ack  out  1  1-clock pulse: SPI access complete
- bus_addr  out  17  registered bus address to decoder and RAM
- bus_we  out  1  registered write enable
- bus_strobe  out  1  data/chip-enable qualifier
- owner  out  2  0=NONE, 1=VIDEO, 2=CPU, 3=SPI
- cpu_clk_en  out  1  1-clock pulse advancing the 6502

Behaviour:
- State machine: S_VIDEO -> S_CPU -> S_SPI -> S_VIDEO.
- The transition occurs when slot counter cnt == SLOT_CLKS-1; cnt then wraps to 0.
- Grant sampling: video_req/spi_req are sampled on the clock edge that enters cnt=0 of their slot. CPU slot is always granted.
- On entry to a granted slot (same edge), the following register and stay stable for the whole slot:
  - bus_addr = VRAM_BASE | {5'b0, video_addr} (VIDEO), {1'b0, cpu_addr} (CPU), or spi_addr (SPI)
  - bus_we = 0 (VIDEO), cpu_we (CPU), or spi_we (SPI)
  - owner = slot code
- Ungranted slot:
  - owner = 0, bus_we = 0, bus_strobe = 0.
  - bus_addr holds its previous value.
  - No ack is issued.
- bus_strobe = 1 for cnt in 1..SLOT_CLKS-2 of a granted slot; 0 otherwise.
- Ack timing (cnt == SLOT_CLKS-1 of a granted slot):
  - video_ack = 1 in a granted VIDEO slot.
  - spi_ack = 1 in a granted SPI slot.
  - cpu_clk_en = 1 in every CPU slot.
  - Each is exactly one clock wide.
- Requester rules:
  - A requester must drop req (or present a new address) in the clock after its ack.
  - A req still high at the next slot entry is granted again.
- Request timing:
  - Requests asserted mid-slot wait for the next frame.
  - Requests dropped before slot entry are not granted.
  - Requests dropped mid-slot do not abort the access; its ack still fires.
- Inputs are not re-sampled mid-slot; address and we changes inside a slot are ignored.
- Reset (synchronous, any cycle, including mid-slot):
  - state = S_VIDEO, cnt = 0.
  - bus_addr = 0, bus_we = 0, bus_strobe = 0, owner = 0.
  - All acks and cpu_clk_en = 0.
  - An in-flight access is abandoned without ack.
- First cycle after reset release: the S_VIDEO slot entry sample is taken. cpu_clk_en first pulses at clock 2*SLOT_CLKS-1 after release.
- No combinational path from any input to any output.

Test Plan:
1. Idle after reset (SLOT_CLKS=4), no video/spi req:
   - cpu_clk_en pulses at clocks 7, 19, 31 after release (period 12).
   - owner = 2 only during clocks 4-7.
   - bus_strobe high at clocks 5-6.
2. CPU write cpu_addr=16'hE810, cpu_we=1:
   - bus_addr = 17'h0E810 and bus_we = 1 throughout the CPU slot.
   - bus_we = 0 in the following empty SPI slot.
3. video_req=1 with video_addr=12'h3FF held across frames:
   - bus_addr = 17'h083FF, owner = 1 in every VIDEO slot.
   - video_ack pulses at clocks 3, 15, 27.
4. spi_req with spi_addr=17'h1F000, spi_we=1, asserted at clock 9 and dropped after ack:
   - Granted in the SPI slot at clocks 8-11? No: the clock-8 sample misses it, so it is granted at clocks 20-23.
   - spi_ack at clock 23; exactly one access.
5. All three requesters active:
   - Strict VIDEO/CPU/SPI order every frame.
   - owner sequence per frame: 1,1,1,1, 2,2,2,2, 3,3,3,3.
6. reset asserted at cnt=2 of a granted SPI slot:
   - No spi_ack.
   - All outputs 0 on the next clock.
   - Sequencing restarts in S_VIDEO after release.
